spi_slave_port: RTL and testbench

System-clock-domain SPI responder (mode 0, CPOL=0/CPHA=0) that sits at the far end of the SPI link from the existing master. It oversamples the external `sclk`/`cs_n`/`mosi` pins with `clk`, shifts a preloaded transmit word out on `miso`, and delivers each received word as a single-cycle strobe. It supports multi-word bursts within one `cs_n` assertion, through a one-entry transmit buffer with a valid/ready handshake.

---
 rtl/spi_pkg.sv | 13 +
 rtl/spi_slave_port_if.sv | 31 +++
 rtl/spi_sync_edge.sv | 41 ++++
 rtl/spi_slave_port.sv | 179 +++++++++++++++++
 tb/tb_spi_slave_port.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// Shared SPI definitions: transfer FSM encoding and default word width,
// common to the master and the responder.
package spi_pkg;

  localparam int SPI_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } spi_state_e;

endpackage

// File: rtl/spi_slave_port_if.sv
// SPI pin group plus the transmit/receive word handshake of the responder.
interface spi_slave_port_if
  import spi_pkg::*;
#(
  parameter int WIDTH = SPI_WIDTH
);

  logic             sclk;
  logic             cs_n;
  logic             mosi;
  logic             miso;
  logic             miso_en;
  logic [WIDTH-1:0] tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic [WIDTH-1:0] rx_data;
  logic             rx_valid;
  logic             underrun;
  logic             abort;

  modport slave (
    input  sclk, cs_n, mosi, tx_data, tx_valid,
    output miso, miso_en, tx_ready, rx_data, rx_valid, underrun, abort
  );

  modport master (
    output sclk, cs_n, mosi, tx_data, tx_valid,
    input  miso, miso_en, tx_ready, rx_data, rx_valid, underrun, abort
  );

endinterface

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer for an asynchronous pin, with registered one-cycle
// rise/fall strobes that lag the pin by three clk cycles.
module spi_sync_edge #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta_r;
  logic sync_r;
  logic prev_r;
  logic rise_r;
  logic fall_r;

  // Synchronizer chain and edge strobe registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_r <= RESET_VAL;
      sync_r <= RESET_VAL;
      prev_r <= RESET_VAL;
      rise_r <= 1'b0;
      fall_r <= 1'b0;
    end else begin
      meta_r <= din;
      sync_r <= meta_r;
      prev_r <= sync_r;
      rise_r <= sync_r & ~prev_r;
      fall_r <= ~sync_r & prev_r;
    end
  end

  assign level = sync_r;
  assign rise  = rise_r;
  assign fall  = fall_r;

endmodule

// File: rtl/spi_slave_port.sv
// Mode-0 SPI responder oversampled by clk: shifts buffered words out on miso,
// strobes out each received word, and supports multi-word bursts per select.
module spi_slave_port
  import spi_pkg::*;
#(
  parameter int               WIDTH     = SPI_WIDTH,
  parameter logic [WIDTH-1:0] IDLE_WORD = {WIDTH{1'b1}}
) (
  input  logic           clk,
  input  logic           reset,
  spi_slave_port_if.slave bus
);

  localparam int               CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  logic sclk_level_s, sclk_rise_s, sclk_fall_s;
  logic cs_level_s, cs_rise_s, cs_fall_s;
  logic mosi_s, mosi_rise_s, mosi_fall_s;
  logic unused_s;

  spi_state_e       state_r, state_s;
  logic             do_load_s, do_shift_s, do_sample_s, do_stop_s;
  logic [WIDTH-1:0] load_word_s;

  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] tx_sh_r;
  logic [WIDTH-1:0] rx_sh_r;
  logic [WIDTH-1:0] rx_data_r;
  logic [WIDTH-1:0] buf_r;
  logic             buf_empty_r;
  logic             reload_r;
  logic             miso_r;
  logic             miso_en_r;
  logic             rx_valid_r;
  logic             underrun_r;
  logic             abort_r;

  spi_sync_edge #(.RESET_VAL(1'b0)) u_sclk_sync (
    .clk(clk), .reset(reset), .din(bus.sclk),
    .level(sclk_level_s), .rise(sclk_rise_s), .fall(sclk_fall_s)
  );

  spi_sync_edge #(.RESET_VAL(1'b1)) u_cs_sync (
    .clk(clk), .reset(reset), .din(bus.cs_n),
    .level(cs_level_s), .rise(cs_rise_s), .fall(cs_fall_s)
  );

  spi_sync_edge #(.RESET_VAL(1'b0)) u_mosi_sync (
    .clk(clk), .reset(reset), .din(bus.mosi),
    .level(mosi_s), .rise(mosi_rise_s), .fall(mosi_fall_s)
  );

  assign unused_s    = ^{sclk_level_s, cs_level_s, mosi_rise_s, mosi_fall_s};
  assign load_word_s = buf_empty_r ? IDLE_WORD : buf_r;

  // FSM state register and pad enable.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= IDLE;
      miso_en_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      miso_en_r <= (state_s != IDLE);
    end
  end

  // Next state and datapath commands; a select rise masks any same-cycle sclk edge.
  always_comb begin
    state_s     = state_r;
    do_load_s   = 1'b0;
    do_shift_s  = 1'b0;
    do_sample_s = 1'b0;
    do_stop_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (cs_fall_s) begin
          state_s   = LOAD;
          do_load_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      LOAD: begin
        if (cs_rise_s) begin
          state_s   = IDLE;
          do_stop_s = 1'b1;
        end else begin
          state_s = SHIFT;
        end
      end
      SHIFT: begin
        if (cs_rise_s) begin
          state_s   = IDLE;
          do_stop_s = 1'b1;
        end else if (sclk_rise_s) begin
          do_sample_s = 1'b1;
        end else if (sclk_fall_s) begin
          if (reload_r) begin
            do_load_s = 1'b1;
          end else begin
            do_shift_s = 1'b1;
          end
        end else begin
          state_s = SHIFT;
        end
      end
      default: begin
        state_s   = IDLE;
        do_stop_s = 1'b1;
      end
    endcase
  end

  // Shift registers, bit counter and status strobes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r      <= {CNT_W{1'b0}};
      tx_sh_r    <= {WIDTH{1'b0}};
      rx_sh_r    <= {WIDTH{1'b0}};
      rx_data_r  <= {WIDTH{1'b0}};
      reload_r   <= 1'b0;
      miso_r     <= 1'b0;
      rx_valid_r <= 1'b0;
      underrun_r <= 1'b0;
      abort_r    <= 1'b0;
    end else begin
      rx_valid_r <= 1'b0;
      underrun_r <= 1'b0;
      abort_r    <= 1'b0;
      if (do_stop_s) begin
        abort_r  <= (cnt_r != {CNT_W{1'b0}});
        cnt_r    <= {CNT_W{1'b0}};
        reload_r <= 1'b0;
        miso_r   <= 1'b0;
      end else if (do_load_s) begin
        tx_sh_r    <= load_word_s;
        miso_r     <= load_word_s[WIDTH-1];
        underrun_r <= buf_empty_r;
        reload_r   <= 1'b0;
      end else if (do_shift_s) begin
        tx_sh_r <= {tx_sh_r[WIDTH-2:0], 1'b0};
        miso_r  <= tx_sh_r[WIDTH-2];
      end else if (do_sample_s) begin
        rx_sh_r <= {rx_sh_r[WIDTH-2:0], mosi_s};
        if (cnt_r == LAST_BIT) begin
          rx_data_r  <= {rx_sh_r[WIDTH-2:0], mosi_s};
          rx_valid_r <= 1'b1;
          cnt_r      <= {CNT_W{1'b0}};
          reload_r   <= 1'b1;
        end else begin
          cnt_r <= cnt_r + CNT_W'(1);
        end
      end
    end
  end

  // One-entry transmit buffer; a fill in a load cycle lands after the load.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      buf_r       <= {WIDTH{1'b0}};
      buf_empty_r <= 1'b1;
    end else if (bus.tx_valid && buf_empty_r) begin
      buf_r       <= bus.tx_data;
      buf_empty_r <= 1'b0;
    end else if (do_load_s) begin
      buf_empty_r <= 1'b1;
    end
  end

  assign bus.miso     = miso_r;
  assign bus.miso_en  = miso_en_r;
  assign bus.tx_ready = buf_empty_r;
  assign bus.rx_data  = rx_data_r;
  assign bus.rx_valid = rx_valid_r;
  assign bus.underrun = underrun_r;
  assign bus.abort    = abort_r;

endmodule

// File: tb/tb_spi_slave_port.sv
// Directed bench for spi_slave_port: the bench plays the SPI master on the
// pins and the word source on the transmit handshake.
module tb_spi_slave_port;

  logic clk;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   rx_cnt = 0;
  int   ur_cnt = 0;
  int   ab_cnt = 0;
  logic [7:0] rx_q[$];

  spi_slave_port_if #(.WIDTH(8)) bus ();

  spi_slave_port #(.WIDTH(8), .IDLE_WORD(8'hFF)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.rx_valid) begin
      rx_cnt <= rx_cnt + 1;
      rx_q.push_back(bus.rx_data);
    end
    if (bus.underrun) ur_cnt <= ur_cnt + 1;
    if (bus.abort) ab_cnt <= ab_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] w);
    bit done;
    done = 1'b0;
    bus.tx_data  = w;
    bus.tx_valid = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      if (bus.tx_ready) done = 1'b1;
      @(negedge clk);
    end
    bus.tx_valid = 1'b0;
    check("push_timeout", 32'(done), 32'd1);
  endtask

  task automatic xfer(input logic [7:0] dout, input int nbits, input int half,
                      input bit end_frame, output logic [7:0] din);
    din = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      bus.mosi = dout[7-i];
      repeat (half) @(negedge clk);
      din = {din[6:0], bus.miso};
      bus.sclk = 1'b1;
      repeat (half) @(negedge clk);
      bus.sclk = 1'b0;
      if (end_frame && (i == nbits - 1)) bus.cs_n = 1'b1;
    end
  endtask

  task automatic t_aa_cc(input int half, input string sfx);
    logic [7:0] got;
    int rx0, ur0, ab0;
    rx0 = rx_cnt; ur0 = ur_cnt; ab0 = ab_cnt;
    push(8'hCC);
    check({"full_ready_", sfx}, 32'(bus.tx_ready), 32'd0);
    bus.cs_n = 1'b0;
    repeat (8) @(negedge clk);
    check({"miso_en_sel_", sfx}, 32'(bus.miso_en), 32'd1);
    check({"miso_first_", sfx}, 32'(bus.miso), 32'd1);
    xfer(8'hAA, 8, half, 1'b1, got);
    repeat (10) @(negedge clk);
    check({"master_rx_", sfx}, 32'(got), 32'hCC);
    check({"rx_data_", sfx}, 32'(bus.rx_data), 32'hAA);
    check({"rx_pulses_", sfx}, 32'(rx_cnt - rx0), 32'd1);
    check({"no_underrun_", sfx}, 32'(ur_cnt - ur0), 32'd0);
    check({"no_abort_", sfx}, 32'(ab_cnt - ab0), 32'd0);
    check({"miso_en_desel_", sfx}, 32'(bus.miso_en), 32'd0);
  endtask

  initial begin
    logic [7:0] g0, g1;
    int rx0, ur0, ab0;
    reset        = 1'b0;
    bus.cs_n     = 1'b1;
    bus.sclk     = 1'b0;
    bus.mosi     = 1'b0;
    bus.tx_data  = 8'h00;
    bus.tx_valid = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_miso", 32'(bus.miso), 32'd0);
    check("rst_miso_en", 32'(bus.miso_en), 32'd0);
    check("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
    check("rst_underrun", 32'(bus.underrun), 32'd0);
    check("rst_abort", 32'(bus.abort), 32'd0);
    check("rst_rx_data", 32'(bus.rx_data), 32'd0);
    check("rst_tx_ready", 32'(bus.tx_ready), 32'd1);
    reset = 1'b1;
    repeat (4) @(negedge clk);

    // Basic exchange at clk/8.
    t_aa_cc(4, "div8");

    // Two-word burst with the second word supplied during byte 0.
    rx0 = rx_cnt; ur0 = ur_cnt;
    push(8'h12);
    bus.cs_n = 1'b0;
    repeat (8) @(negedge clk);
    push(8'h34);
    check("burst_buf_full", 32'(bus.tx_ready), 32'd0);
    xfer(8'hA5, 8, 8, 1'b0, g0);
    xfer(8'h5A, 8, 8, 1'b1, g1);
    repeat (10) @(negedge clk);
    check("burst_master0", 32'(g0), 32'h12);
    check("burst_master1", 32'(g1), 32'h34);
    check("burst_rx_pulses", 32'(rx_cnt - rx0), 32'd2);
    check("burst_rx0", 32'(rx_q[$-1]), 32'hA5);
    check("burst_rx1", 32'(rx_q[$]), 32'h5A);
    check("burst_no_underrun", 32'(ur_cnt - ur0), 32'd0);

    // Underrun with empty buffer.
    rx0 = rx_cnt; ur0 = ur_cnt;
    check("ur_ready", 32'(bus.tx_ready), 32'd1);
    bus.cs_n = 1'b0;
    repeat (8) @(negedge clk);
    xfer(8'h3C, 8, 8, 1'b1, g0);
    repeat (10) @(negedge clk);
    check("ur_master", 32'(g0), 32'hFF);
    check("ur_pulses", 32'(ur_cnt - ur0), 32'd1);
    check("ur_rx_data", 32'(bus.rx_data), 32'h3C);
    check("ur_rx_pulses", 32'(rx_cnt - rx0), 32'd1);

    // Abort after three bits, then a clean frame.
    rx0 = rx_cnt; ab0 = ab_cnt;
    bus.cs_n = 1'b0;
    repeat (8) @(negedge clk);
    xfer(8'hE7, 3, 8, 1'b1, g0);
    repeat (10) @(negedge clk);
    check("ab_pulses", 32'(ab_cnt - ab0), 32'd1);
    check("ab_no_rx", 32'(rx_cnt - rx0), 32'd0);
    check("ab_rx_held", 32'(bus.rx_data), 32'h3C);
    push(8'h7E);
    bus.cs_n = 1'b0;
    repeat (8) @(negedge clk);
    xfer(8'h81, 8, 8, 1'b1, g0);
    repeat (10) @(negedge clk);
    check("ab_next_rx", 32'(bus.rx_data), 32'h81);
    check("ab_next_master", 32'(g0), 32'h7E);
    check("ab_single", 32'(ab_cnt - ab0), 32'd1);

    // Reset in the middle of a word with the buffer full.
    push(8'h55);
    bus.cs_n = 1'b0;
    repeat (8) @(negedge clk);
    push(8'h77);
    xfer(8'hC3, 5, 8, 1'b0, g0);
    check("mid_buf_full", 32'(bus.tx_ready), 32'd0);
    rx0 = rx_cnt; ab0 = ab_cnt;
    reset = 1'b0;
    #1;
    check("mid_rst_miso", 32'(bus.miso), 32'd0);
    check("mid_rst_miso_en", 32'(bus.miso_en), 32'd0);
    check("mid_rst_rx_valid", 32'(bus.rx_valid), 32'd0);
    check("mid_rst_underrun", 32'(bus.underrun), 32'd0);
    check("mid_rst_abort", 32'(bus.abort), 32'd0);
    check("mid_rst_rx_data", 32'(bus.rx_data), 32'd0);
    check("mid_rst_tx_ready", 32'(bus.tx_ready), 32'd1);
    @(negedge clk);
    bus.cs_n = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    check("post_rst_no_rx", 32'(rx_cnt - rx0), 32'd0);
    check("post_rst_no_abort", 32'(ab_cnt - ab0), 32'd0);
    check("post_rst_idle", 32'(bus.miso_en), 32'd0);
    push(8'hF0);
    bus.cs_n = 1'b0;
    repeat (8) @(negedge clk);
    xfer(8'h0F, 8, 8, 1'b1, g0);
    repeat (10) @(negedge clk);
    check("post_rst_rx", 32'(bus.rx_data), 32'h0F);
    check("post_rst_master", 32'(g0), 32'hF0);

    // Same exchange at clk/32.
    t_aa_cc(16, "div32");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
